// File: rtl/test_00_stim_pkg.sv
// test_00_stim_pkg: shared types and constants for the test_00 stimulus driver.
// Holds the run-state encoding and the LFSR polynomial, default seed and step function.
package test_00_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DUTRST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int LFSR_W = 16;

    // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // One left shift with the tap parity fed back into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/test_00_stim_lfsr.sv
// test_00_stim_lfsr: 16-bit Fibonacci LFSR supplying the stimulus vectors.
// A zero seed would lock the register at zero, so it is replaced by the default seed.
module test_00_stim_lfsr
    import test_00_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] seed_eff;

    // Substitute the default seed for an all-zero seed.
    always_comb begin
        seed_eff = (seed == '0) ? LFSR_SEED : seed;
    end

    // Load has priority over stepping; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= seed_eff;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/test_00_stim.sv
// test_00_stim: self-checking stimulus driver for the test_00 register-capture block.
// Optional macro TEST_00_STIM_STOP_ON_ERR_EN ends a run at the first mismatch.
module test_00_stim
    import test_00_stim_pkg::*;
#(
    parameter int NUM_VECTORS = 64,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [15:0]      i_seed,
    output logic             o_dut_rst_n,
    output logic             o_dut_test_sig,
    output logic             o_dut_a,
    output logic             o_dut_b,
    output logic             o_dut_c,
    input  logic             i_dut_a,
    input  logic             i_dut_b,
    input  logic [1:0]       i_dut_c,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_vec_cnt,
    output logic [CNT_W-1:0] o_fail_idx
);

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LAST_RST = CNT_W'(RST_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  rst_cnt;
    logic [CNT_W-1:0]  drv_idx;
    logic [3:0]        drv;
    logic              exp_a;
    logic              exp_b;
    logic [1:0]        exp_c;
    logic              cmp_valid;
    logic              mismatch;
    logic              hit;
    logic              first_hit;
    logic              abort;
    logic              go_run;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr;
    logic              unused_lfsr_hi;

    // Vector bit order is {test_sig, a, b, c}.
    assign {o_dut_test_sig, o_dut_a, o_dut_b, o_dut_c} = drv;

    // Only the low nibble of the LFSR becomes stimulus.
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:4];

    test_00_stim_lfsr u_lfsr (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (lfsr_load),
        .en    (go_run),
        .seed  (i_seed),
        .state (lfsr)
    );

    // Compare result, early-stop decision and next-cycle-is-RUN decode.
    always_comb begin
        mismatch  = {i_dut_a, i_dut_b, i_dut_c} != {exp_a, exp_b, exp_c};
        hit       = cmp_valid && mismatch;
        first_hit = hit && (o_err_cnt == '0);
        lfsr_load = (state == IDLE) && i_start;
        abort     = 1'b0;
        go_run    = 1'b0;
        unique case (state)
            DUTRST: begin
                go_run = (rst_cnt == LAST_RST);
            end
            RUN: begin
`ifdef TEST_00_STIM_STOP_ON_ERR_EN
                abort = hit;
`else
                abort = 1'b0;
`endif
                go_run = !abort && (o_vec_cnt != LAST_VEC);
            end
            default: begin
                go_run = 1'b0;
            end
        endcase
    end

    // Reference model of test_00, stepped by each vector on the wire.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exp_a <= 1'b0;
            exp_b <= 1'b0;
            exp_c <= 2'b00;
        end else if (state == DUTRST) begin
            exp_a <= 1'b0;
            exp_b <= 1'b0;
            exp_c <= 2'b00;
        end else if (state == RUN) begin
            exp_a <= drv[3];
            exp_b <= drv[1];
            if (drv[0]) begin
                exp_c[1] <= 1'b0;
            end else begin
                exp_c[0] <= ~drv[2];
            end
        end
    end

    // Run sequencer with registered handshake, drive and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_dut_rst_n <= 1'b0;
            drv         <= 4'h0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_cnt   <= '0;
            o_vec_cnt   <= '0;
            o_fail_idx  <= '1;
            rst_cnt     <= '0;
            cmp_valid   <= 1'b0;
            drv_idx     <= '0;
        end else begin
            o_done      <= 1'b0;
            cmp_valid   <= 1'b0;
            drv         <= 4'h0;
            o_dut_rst_n <= 1'b1;
            if (hit) begin
                if (o_err_cnt != '1) begin
                    o_err_cnt <= o_err_cnt + 1'b1;
                end
                if (first_hit) begin
                    o_fail_idx <= drv_idx;
                end
            end
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= DUTRST;
                        o_dut_rst_n <= 1'b0;
                        o_busy      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_err_cnt   <= '0;
                        o_vec_cnt   <= '0;
                        o_fail_idx  <= '1;
                        rst_cnt     <= '0;
                    end
                end
                DUTRST: begin
                    if (go_run) begin
                        state <= RUN;
                        drv   <= lfsr[3:0];
                    end else begin
                        o_dut_rst_n <= 1'b0;
                        rst_cnt     <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // The vector on the wire now is checked next cycle.
                    cmp_valid <= !abort;
                    drv_idx   <= o_vec_cnt;
                    if (abort) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        o_pass <= 1'b0;
                    end else begin
                        o_vec_cnt <= o_vec_cnt + 1'b1;
                        if (go_run) begin
                            drv <= lfsr[3:0];
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Include this cycle's compare in the verdict.
                    state  <= DONE;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    o_pass <= !hit && (o_err_cnt == '0);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/test_00_stim.md
Name: test_00_stim

Overview:
- Self-checking stimulus driver for the test_00 register-capture block.
- Generates pseudo-random vectors on the capture block's inputs and drives its active-low synchronous reset.
- Predicts the block's registered outputs with an internal reference model, compares them one cycle later, and reports pass/fail plus mismatch counts.
- Sits beside test_00 in the on-chip test harness.

Parameters:
- NUM_VECTORS, 64, vectors driven per run (1..2^CNT_W-1).
- CNT_W, 16, width of vector and error counters.
- RST_CYCLES, 2, cycles the DUT reset is held low before vectors start (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse; starts a run when idle.
- i_seed  in  16  LFSR seed, sampled on accepted i_start; 0 is replaced by 16'hACE1.
- o_dut_rst_n  out  1  drives test_00 i_rst (active-low).
- o_dut_test_sig  out  1  drives a_test_signal.
- o_dut_a  out  1  drives i_a.
- o_dut_b  out  1  drives i_b.
- o_dut_c  out  1  drives i_c.
- i_dut_a  in  1  from test_00 o_a.
- i_dut_b  in  1  from test_00 o_b.
- i_dut_c  in  2  from test_00 o_c.
- o_busy  out  1  high from accepted start until DONE.
- o_done  out  1  one-cycle pulse at end of run.
- o_pass  out  1  level; valid after o_done, held until next accepted start.
- o_err_cnt  out  CNT_W  mismatching compare cycles; saturates at all-ones.
- o_vec_cnt  out  CNT_W  vectors driven in the current or last run.
- o_fail_idx  out  CNT_W  vector index of the first mismatch; all-ones if none.

Behaviour:
- Reset (i_rst=1, any time, including mid-run):
  - state IDLE; o_dut_rst_n=0; all DUT-drive outputs 0.
  - o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_vec_cnt=0, o_fail_idx=all-ones.
  - LFSR=16'hACE1; model registers 0.
- IDLE: o_dut_rst_n=1.
  - i_start=1: load LFSR with i_seed, clear the counters, set o_fail_idx to all-ones, clear o_pass, go to DUTRST.
  - i_start while not in IDLE is ignored.
- DUTRST: o_dut_rst_n=0 for RST_CYCLES cycles; model regs cleared to 0; then go to RUN.
- RUN: o_dut_rst_n=1, one vector per cycle.
  - Drive {test_sig, a, b, c} = LFSR[3:0].
  - Advance the LFSR every RUN cycle: 16-bit Fibonacci, taps 16, 14, 13, 11, shift left, feedback into bit 0.
  - Increment o_vec_cnt every RUN cycle.
  - After NUM_VECTORS vectors, go to DRAIN.
- Reference model, updated on each driven vector:
  - exp_a <= test_sig; exp_b <= b.
  - If c=1: exp_c[1] <= 0.
  - Else: exp_c[0] <= ~a.
  - Other bit of exp_c holds.
- Compare, 1-cycle latency:
  - Each cycle after a vector was driven (RUN cycles 2..N and the DRAIN cycle), compare {i_dut_a, i_dut_b, i_dut_c} with the model state.
  - On mismatch: increment o_err_cnt.
  - On the first mismatch of a run, capture the index of the vector that produced it into o_fail_idx.
- DRAIN: one compare cycle, DUT inputs held at 0; then go to DONE.
- DONE, one cycle: o_done=1; o_pass = (o_err_cnt==0); o_busy=0; return to IDLE.
- NUM_VECTORS=1: DUTRST -> RUN (1 cycle) -> DRAIN -> DONE.

Optional Feature:
- Macro TEST_00_STIM_STOP_ON_ERR_EN.
- Defined: the first mismatch moves the block straight to DONE on the next cycle. No further vectors are driven; o_vec_cnt freezes; o_err_cnt=1; o_pass=0.
- Undefined: the run always completes NUM_VECTORS vectors and counts every mismatch.
- o_fail_idx behaves identically in both builds.

Decomposition:
- Package test_00_stim_pkg:
  - state enum {IDLE, DUTRST, RUN, DRAIN, DONE}.
  - LFSR width 16, tap mask, default seed 16'hACE1.
- Sub-module test_00_stim_lfsr: load, enable, seed-zero substitution, 16-bit state output.
- FSM, reference model and comparators stay in test_00_stim.

Test Plan:
- Loopback with the real test_00, seed 16'h0001, NUM_VECTORS=64 -> o_done pulse once; o_pass=1, o_err_cnt=0, o_vec_cnt=64, o_fail_idx=16'hFFFF.
- i_dut_b tied 0, seed 16'h0001 -> o_err_cnt = count of driven vectors with b=1 (from an LFSR golden model, nonzero); o_pass=0; o_fail_idx = index of the first b=1 vector.
- Behavioural DUT flips o_a only for vector 5 -> o_err_cnt=1, o_fail_idx=5. With STOP_ON_ERR_EN: o_vec_cnt=6, o_done occurs right after the compare that detects vector 5.
- i_seed=0 -> LFSR loads 16'hACE1; the first vector equals 4'h1 (ACE1[3:0]).
- i_rst pulsed during RUN at vector 10 -> all outputs at reset values the same cycle, o_dut_rst_n=0; a new i_start then completes normally.
- i_start pulsed during RUN, and NUM_VECTORS=1 -> the extra start is ignored (a single o_done); the 1-vector run finishes DONE exactly 3+RST_CYCLES cycles after the start.
